// File: rtl/sys_defs_pkg.sv
// Shared decode definitions: opcodes, immediate kinds, decode bundle.
// Used by decode_issue_stage (optional DECODE_ISSUE_WB_BYPASS_EN).
package sys_defs_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       reg_wr;
        logic       illegal;
        imm_type_e  imm_type;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        d = '0;
        d.rs1 = inst[19:15];
        d.rs2 = inst[24:20];
        d.rd  = inst[11:7];
        unique case (1'b1)
            op == OPC_LUI, op == OPC_AUIPC: begin
                d.reg_wr   = 1'b1;
                d.imm_type = IMM_U;
            end
            op == OPC_JAL: begin
                d.reg_wr   = 1'b1;
                d.imm_type = IMM_J;
            end
            op == OPC_JALR: begin
                d.illegal  = (f3 != 3'b000);
                d.uses_rs1 = 1'b1;
                d.reg_wr   = 1'b1;
                d.imm_type = IMM_I;
            end
            op == OPC_BRANCH: begin
                d.illegal  = (f3[2:1] == 2'b01);
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.imm_type = IMM_B;
            end
            op == OPC_LOAD: begin
                d.illegal  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                d.uses_rs1 = 1'b1;
                d.reg_wr   = 1'b1;
                d.imm_type = IMM_I;
            end
            op == OPC_STORE: begin
                d.illegal  = f3[2] || (f3 == 3'b011);
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.imm_type = IMM_S;
            end
            op == OPC_OPIMM: begin
                d.illegal  = ((f3 == 3'b001) && (f7 != 7'b0))
                          || ((f3 == 3'b101) && (f7 != 7'b0)
                              && (f7 != 7'b0100000));
                d.uses_rs1 = 1'b1;
                d.reg_wr   = 1'b1;
                d.imm_type = IMM_I;
            end
            op == OPC_OP: begin
                d.illegal  = !((f7 == 7'b0)
                            || ((f7 == 7'b0100000)
                                && ((f3 == 3'b000) || (f3 == 3'b101))));
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.reg_wr   = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        // Illegal ops issue as inert bubbles: no reads, no writes.
        if (d.illegal) begin
            d.uses_rs1 = 1'b0;
            d.uses_rs2 = 1'b0;
            d.reg_wr   = 1'b0;
            d.imm_type = IMM_NONE;
        end
        if (!d.reg_wr) d.rd = '0;
        return d;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] inst,
                                            input imm_type_e t);
        logic [31:0] imm;
        case (t)
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {inst[31:12], 12'b0};
            IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/sb_regfile.sv
// Architectural register file: 2 async read ports, 1 write port.
// x0 always reads zero; a same-cycle write is not forwarded.
module sb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] ra1_i,
    input  logic [IDX_W-1:0] ra2_i,
    output logic [XLEN-1:0]  rd1_o,
    output logic [XLEN-1:0]  rd2_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wa_i,
    input  logic [XLEN-1:0]  wd_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage with scoreboard and operand read.
// Define DECODE_ISSUE_WB_BYPASS_EN to forward writeback into issue.
module decode_issue_stage
    import sys_defs_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic             wb_we,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output logic [XLEN-1:0]  out_imm,
    output logic [IDX_W-1:0] out_rd,
    output logic             out_reg_wr,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic             out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [IDX_W-1:0] rd;
        logic             reg_wr;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             illegal;
    } id_ex_t;

    dec_t              dec;
    logic [IDX_W-1:0]  rs1, rs2, rd;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   rf_a, rf_b, op_a, op_b;
    logic [NREGS-1:0]  pend_q, pend_d, pend_eff, wb_clr;
    logic              hazard, accept;
    logic              vld_q, vld_d;
    id_ex_t            ex_q, ex_d;

    assign dec   = decode(in_inst);
    assign rs1   = IDX_W'(dec.rs1);
    assign rs2   = IDX_W'(dec.rs2);
    assign rd    = IDX_W'(dec.rd);
    assign imm32 = imm_gen(in_inst, dec.imm_type);

    sb_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rf_a),
        .rd2_o (rf_b),
        .we_i  (wb_valid && wb_we),
        .wa_i  (wb_idx),
        .wd_i  (wb_data)
    );

    assign wb_clr = wb_valid ? (NREGS'(1) << wb_idx) : '0;

`ifdef DECODE_ISSUE_WB_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok   = wb_valid && wb_we && (wb_idx != '0);
    assign pend_eff = pend_q & ~wb_clr;
    assign op_a     = (fwd_ok && (wb_idx == rs1)) ? wb_data : rf_a;
    assign op_b     = (fwd_ok && (wb_idx == rs2)) ? wb_data : rf_b;
`else
    assign pend_eff = pend_q;
    assign op_a     = rf_a;
    assign op_b     = rf_b;
`endif

    assign hazard = in_valid
        && ((dec.uses_rs1 && (rs1 != '0) && pend_eff[rs1])
         || (dec.uses_rs2 && (rs2 != '0) && pend_eff[rs2])
         || (dec.reg_wr   && (rd  != '0) && pend_eff[rd]));

    assign in_ready = rst && !hazard && !flush
                   && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        ex_d  = ex_q;
        vld_d = vld_q;
        if (out_ready) vld_d = 1'b0;
        if (accept) begin
            vld_d         = 1'b1;
            ex_d.pc       = in_pc;
            ex_d.rs1_val  = op_a;
            ex_d.rs2_val  = op_b;
            ex_d.imm      = XLEN'(imm32);
            ex_d.rd       = rd;
            ex_d.reg_wr   = dec.reg_wr;
            ex_d.opcode   = in_inst[6:0];
            ex_d.funct3   = in_inst[14:12];
            ex_d.illegal  = dec.illegal;
        end
        if (flush) vld_d = 1'b0;
    end

    // Set is applied after the clears so a same-index set wins.
    always_comb begin
        pend_d = pend_q & ~wb_clr;
        if (flush && vld_q && ex_q.reg_wr) pend_d[ex_q.rd] = 1'b0;
        if (accept && dec.reg_wr && (rd != '0) && !dec.illegal)
            pend_d[rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            ex_q   <= '0;
            pend_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ex_q   <= ex_d;
            pend_q <= pend_d;
        end
    end

    assign out_valid   = vld_q;
    assign out_pc      = ex_q.pc;
    assign out_rs1_val = ex_q.rs1_val;
    assign out_rs2_val = ex_q.rs2_val;
    assign out_imm     = ex_q.imm;
    assign out_rd      = ex_q.rd;
    assign out_reg_wr  = ex_q.reg_wr;
    assign out_opcode  = ex_q.opcode;
    assign out_funct3  = ex_q.funct3;
    assign out_illegal = ex_q.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage.
// Build with DECODE_ISSUE_WB_BYPASS_EN to check the forwarding variant.
module tb_decode_issue_stage;

    localparam int XLEN  = 32;
    localparam int IDX_W = 5;

    localparam logic [31:0] ADDI5  = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] ADD6   = 32'h0052_8333; // add x6,x5,x5
    localparam logic [31:0] LUI1   = 32'h1234_50B7; // lui x1,0x12345
    localparam logic [31:0] ADD2   = 32'h0000_8133; // add x2,x1,x0
    localparam logic [31:0] ADDI9  = 32'h0010_0493; // addi x9,x0,1
    localparam logic [31:0] ADD10  = 32'h0004_8533; // add x10,x9,x0
    localparam logic [31:0] ILL    = 32'h0000_047F; // opcode 0x7F, rd=8
    localparam logic [31:0] ADD11  = 32'h0004_05B3; // add x11,x8,x0
    localparam logic [31:0] ADDX0  = 32'h0020_8033; // add x0,x1,x2

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             wb_valid;
    logic             wb_we;
    logic [IDX_W-1:0] wb_idx;
    logic [XLEN-1:0]  wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_rs1_val;
    logic [XLEN-1:0]  out_rs2_val;
    logic [XLEN-1:0]  out_imm;
    logic [IDX_W-1:0] out_rd;
    logic             out_reg_wr;
    logic [6:0]       out_opcode;
    logic [2:0]       out_funct3;
    logic             out_illegal;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decode_issue_stage #(.XLEN(XLEN), .NREGS(32), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_reg_wr  (out_reg_wr),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_illegal (out_illegal)
    );

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_we     = 1'b0;
        wb_idx    = '0;
        wb_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        in_inst   = ADDI5;
        in_pc     = 32'h40;
        out_ready = 1'b1;
        rst       = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_valid got %0h want 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL rst_in_ready got %0h want 0", in_ready);
        else passed++;
        total++;
        if (out_pc !== 32'h0 || out_imm !== 32'h0 || out_rd !== 5'd0)
            $display("FAIL rst_fields pc=%0h imm=%0h rd=%0d want 0",
                     out_pc, out_imm, out_rd);
        else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_raw_stall();
        apply_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = ADDI5;
        in_pc    = 32'h100;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL raw_first_ready got %0h want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_inst = ADD6;
        in_pc   = 32'h104;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_imm !== 32'd7)
            $display("FAIL raw_addi v=%0h rd=%0d imm=%0h want 1/5/7",
                     out_valid, out_rd, out_imm);
        else passed++;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL raw_stall got %0h want 0", in_ready);
        else passed++;
        @(posedge clk); #2;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL raw_stall2 rdy=%0h v=%0h want 0/0",
                     in_ready, out_valid);
        else passed++;
        wb_valid = 1'b1;
        wb_we    = 1'b1;
        wb_idx   = 5'd5;
        wb_data  = 32'd7;
        #1;
`ifdef DECODE_ISSUE_WB_BYPASS_EN
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL raw_wb_cycle_ready got %0h want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        wb_we    = 1'b0;
        in_valid = 1'b0;
        #1;
`else
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL raw_wb_cycle_ready got %0h want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        wb_we    = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL raw_after_wb_ready got %0h want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
`endif
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_rd !== 5'd6)
            $display("FAIL raw_issue v=%0h pc=%0h rd=%0d want 1/104/6",
                     out_valid, out_pc, out_rd);
        else passed++;
        total++;
        if (out_rs1_val !== 32'd7 || out_rs2_val !== 32'd7)
            $display("FAIL raw_operands a=%0h b=%0h want 7/7",
                     out_rs1_val, out_rs2_val);
        else passed++;
    endtask

    task automatic test_lui();
        apply_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = LUI1;
        in_pc    = 32'h200;
        @(posedge clk); #1;
        in_inst = ADD2;
        in_pc   = 32'h204;
        #1;
        total++;
        if (out_imm !== 32'h1234_5000)
            $display("FAIL lui_imm got %0h want 12345000", out_imm);
        else passed++;
        total++;
        if (out_reg_wr !== 1'b1 || out_rd !== 5'd1 || out_opcode !== 7'h37)
            $display("FAIL lui_fields wr=%0h rd=%0d op=%0h want 1/1/37",
                     out_reg_wr, out_rd, out_opcode);
        else passed++;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL lui_pending1 ready=%0h want 0", in_ready);
        else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = ADDI9;
        in_pc    = 32'h300;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd9 || out_pc !== 32'h300)
            $display("FAIL flush_held v=%0h rd=%0d pc=%0h want 1/9/300",
                     out_valid, out_rd, out_pc);
        else passed++;
        flush = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = ADD10;
        in_pc     = 32'h304;
        #1;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_valid got %0h want 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL flush_pending9 ready=%0h want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        apply_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = ILL;
        in_pc    = 32'h400;
        @(posedge clk); #1;
        in_inst = ADD11;
        in_pc   = 32'h404;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1)
            $display("FAIL ill_flag v=%0h ill=%0h want 1/1",
                     out_valid, out_illegal);
        else passed++;
        total++;
        if (out_rd !== 5'd0 || out_reg_wr !== 1'b0)
            $display("FAIL ill_rd rd=%0d wr=%0h want 0/0",
                     out_rd, out_reg_wr);
        else passed++;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL ill_no_pending ready=%0h want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_illegal !== 1'b0 || out_rd !== 5'd11)
            $display("FAIL ill_next ill=%0h rd=%0d want 0/11",
                     out_illegal, out_rd);
        else passed++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = ADDX0;
        in_pc    = 32'h500;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b1)
                $display("FAIL b2b_ready%0d got %0h want 1", i, in_ready);
            else passed++;
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h500 + 32'(4 * i))
                $display("FAIL b2b_issue%0d v=%0h pc=%0h want 1/%0h",
                         i, out_valid, out_pc, 32'h500 + 32'(4 * i));
            else passed++;
            in_pc = 32'h504 + 32'(4 * i);
        end
        #1;
        total++;
        if (out_rd !== 5'd0 || out_reg_wr !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL b2b_x0 rd=%0d wr=%0h rdy=%0h want 0/1/1",
                     out_rd, out_reg_wr, in_ready);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b0)
            $display("FAIL b2b_async_rst v=%0h pc=%0h rdy=%0h want 0/0/0",
                     out_valid, out_pc, in_ready);
        else passed++;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_lui();
        test_flush();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
